// File: rtl/raw2rgb_pkg.sv
// Shared constants and helpers for the Bayer RAW-to-RGB demosaic.
// Optional white-balance gain stage is enabled with RAW2RGB_WB_GAIN_EN.
package raw2rgb_pkg;

    localparam logic [1:0] PH_RGGB = 2'd0;
    localparam logic [1:0] PH_GRBG = 2'd1;
    localparam logic [1:0] PH_GBRG = 2'd2;
    localparam logic [1:0] PH_BGGR = 2'd3;

    localparam logic [1:0] DEC_FULL = 2'd0;
    localparam logic [1:0] DEC_2X   = 2'd1;
    localparam logic [1:0] DEC_4X   = 2'd2;

    localparam logic [7:0] GAIN_ONE = 8'h40;

    // Colour of the bottom-right window sample, after phase correction
    typedef enum logic [1:0] {
        PosR  = 2'b00,
        PosGr = 2'b01,
        PosGb = 2'b10,
        PosB  = 2'b11
    } bayerPos_e;

    // Reserved decimation code falls into the 4x branch
    function automatic logic decimGate(input logic [1:0] decim, input logic [1:0] x,
                                       input logic [1:0] y);
        case (decim)
            DEC_FULL: decimGate = 1'b1;
            DEC_2X:   decimGate = x[0] & y[0];
            default:  decimGate = (&x) & (&y);
        endcase
    endfunction

endpackage

// File: rtl/bayer_line_buffer.sv
// One-line delay for the demosaic window, addressed by column so any line
// width up to LINE_W lines up; the tap is the value stored before this write.
module bayer_line_buffer #(
    parameter int DW     = 12,
    parameter int LINE_W = 1280
) (
    input  logic                      iCLK,
    input  logic                      iEN,
    input  logic [$clog2(LINE_W)-1:0] iADDR,
    input  logic [DW-1:0]             iDATA,
    output logic [DW-1:0]             oTAP
);

    logic [DW-1:0] mem [LINE_W];

    always_ff @(posedge iCLK) begin
        if (iEN) begin
            mem[iADDR] <= iDATA;
        end
    end

    assign oTAP = mem[iADDR];

endmodule

// File: rtl/raw2rgb_bayer_param.sv
// Bayer RAW-to-RGB demosaic: 2x2 window, runtime phase and decimation, 2-stage pipeline.
// Define RAW2RGB_WB_GAIN_EN to add the Q2.6 red/blue white-balance gain stage.
module raw2rgb_bayer_param
    import raw2rgb_pkg::*;
#(
    parameter int DW     = 12,
    parameter int CW     = 11,
    parameter int LINE_W = 1280
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic [CW-1:0] iX_Cont,
    input  logic [CW-1:0] iY_Cont,
    input  logic [1:0]    iBAYER_PHASE,
    input  logic [1:0]    iDECIM,
`ifdef RAW2RGB_WB_GAIN_EN
    input  logic [7:0]    iWB_R_GAIN,
    input  logic [7:0]    iWB_B_GAIN,
`endif
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue,
    output logic          oDVAL,
    output logic          oSOF
);

    localparam int AW = $clog2(LINE_W);

    logic [1:0]    phaseSh;
    logic [1:0]    decimSh;
    logic          armed;
    logic          sofPending;
    logic [DW-1:0] curD;
    logic [DW-1:0] prevD;
    logic [DW-1:0] prevTap;

    logic          frameStart;
    logic          complete;
    logic          valid0;
    logic [1:0]    pos;
    logic [DW-1:0] rSel;
    logic [DW-1:0] bSel;
    logic [DW:0]   gSum;

    logic [DW-1:0] red1;
    logic [DW-1:0] green1;
    logic [DW-1:0] blue1;
    logic          val1;
    logic          sof1;
    logic [DW-1:0] redS;
    logic [DW-1:0] blueS;

    bayer_line_buffer #(
        .DW     (DW),
        .LINE_W (LINE_W)
    ) uLineBuf (
        .iCLK  (iCLK),
        .iEN   (iDVAL),
        .iADDR (iX_Cont[AW-1:0]),
        .iDATA (iDATA),
        .oTAP  (prevTap)
    );

    assign frameStart = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    assign complete   = (iX_Cont != '0) && (iY_Cont != '0);
    assign valid0     = armed && iDVAL && complete && decimGate(decimSh, iX_Cont[1:0], iY_Cont[1:0]);
    assign pos        = {iY_Cont[0], iX_Cont[0]} ^ phaseSh;

    // Window: iDATA bottom-right, curD bottom-left, prevTap top-right, prevD top-left
    always_comb begin
        rSel = iDATA;
        bSel = iDATA;
        gSum = '0;
        unique case (bayerPos_e'(pos))
            PosR: begin
                rSel = iDATA;
                bSel = prevD;
                gSum = {1'b0, curD} + {1'b0, prevTap};
            end
            PosGr: begin
                rSel = curD;
                bSel = prevTap;
                gSum = {1'b0, iDATA} + {1'b0, prevD};
            end
            PosGb: begin
                rSel = prevTap;
                bSel = curD;
                gSum = {1'b0, iDATA} + {1'b0, prevD};
            end
            PosB: begin
                rSel = prevD;
                bSel = iDATA;
                gSum = {1'b0, curD} + {1'b0, prevTap};
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            phaseSh    <= '0;
            decimSh    <= '0;
            armed      <= 1'b0;
            sofPending <= 1'b0;
            curD       <= '0;
            prevD      <= '0;
            red1       <= '0;
            green1     <= '0;
            blue1      <= '0;
            val1       <= 1'b0;
            sof1       <= 1'b0;
        end else begin
            if (frameStart) begin
                phaseSh    <= iBAYER_PHASE;
                decimSh    <= iDECIM;
                armed      <= 1'b1;
                sofPending <= 1'b1;
            end else if (valid0) begin
                sofPending <= 1'b0;
            end
            if (iDVAL) begin
                curD  <= iDATA;
                prevD <= prevTap;
            end
            val1 <= valid0;
            sof1 <= valid0 && sofPending;
            if (valid0) begin
                red1   <= rSel;
                green1 <= gSum[DW:1];
                blue1  <= bSel;
            end
        end
    end

`ifdef RAW2RGB_WB_GAIN_EN
    function automatic logic [DW-1:0] applyGain(input logic [DW-1:0] v, input logic [7:0] g);
        logic [DW+7:0] prod;
        prod = ({8'b0, v} * {{DW{1'b0}}, g}) >> $clog2(GAIN_ONE);
        applyGain = (|prod[DW+7:DW]) ? '1 : prod[DW-1:0];
    endfunction

    assign redS  = applyGain(red1, iWB_R_GAIN);
    assign blueS = applyGain(blue1, iWB_B_GAIN);
`else
    assign redS  = red1;
    assign blueS = blue1;
`endif

    // Data registers only load on a valid pixel so outputs hold between pixels
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
            oDVAL  <= 1'b0;
            oSOF   <= 1'b0;
        end else begin
            oDVAL <= val1;
            oSOF  <= sof1;
            if (val1) begin
                oRed   <= redS;
                oGreen <= green1;
                oBlue  <= blueS;
            end
        end
    end

endmodule

// File: tb/tb_raw2rgb_bayer_param.sv
// Randomised self-checking bench for raw2rgb_bayer_param against a mosaic-level model.
// Build with RAW2RGB_WB_GAIN_EN defined to also cover the gain stage.
module tb_raw2rgb_bayer_param;
    import raw2rgb_pkg::*;

    localparam int DW     = 12;
    localparam int CW     = 11;
    localparam int LINE_W = 16;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic [DW-1:0] iDATA = '0;
    logic          iDVAL = 1'b0;
    logic [CW-1:0] iX_Cont = '0;
    logic [CW-1:0] iY_Cont = '0;
    logic [1:0]    iBAYER_PHASE = PH_RGGB;
    logic [1:0]    iDECIM = DEC_FULL;
`ifdef RAW2RGB_WB_GAIN_EN
    logic [7:0]    iWB_R_GAIN = GAIN_ONE;
    logic [7:0]    iWB_B_GAIN = GAIN_ONE;
`endif
    logic [DW-1:0] oRed;
    logic [DW-1:0] oGreen;
    logic [DW-1:0] oBlue;
    logic          oDVAL;
    logic          oSOF;

    raw2rgb_bayer_param #(
        .DW     (DW),
        .CW     (CW),
        .LINE_W (LINE_W)
    ) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iDATA        (iDATA),
        .iDVAL        (iDVAL),
        .iX_Cont      (iX_Cont),
        .iY_Cont      (iY_Cont),
        .iBAYER_PHASE (iBAYER_PHASE),
        .iDECIM       (iDECIM),
`ifdef RAW2RGB_WB_GAIN_EN
        .iWB_R_GAIN   (iWB_R_GAIN),
        .iWB_B_GAIN   (iWB_B_GAIN),
`endif
        .oRed         (oRed),
        .oGreen       (oGreen),
        .oBlue        (oBlue),
        .oDVAL        (oDVAL),
        .oSOF         (oSOF)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: whole-frame pixel store, colour by mosaic parity
    typedef struct {
        int due;
        int r;
        int g;
        int b;
        int sof;
    } exp_t;

    exp_t expQ[$];
    exp_t e;
    int   pix[16][16];
    int   pat[4] = '{'h100, 'h200, 'h300, 'h400};
    int   mArmed = 0;
    int   mPhase = 0;
    int   mDecim = 0;
    int   mSofPend = 0;
    int   outCnt = 0;
    int   sofCnt = 0;

    // 0 = R, 1/2 = G, 3 = B
    function automatic int colourAt(int y, int x, int ph);
        return (((y % 2) * 2) + (x % 2)) ^ ph;
    endfunction

    function automatic int passDecim(int d, int y, int x);
        if (d == 0) return 1;
        if (d == 1) return ((x % 2) == 1 && (y % 2) == 1) ? 1 : 0;
        return ((x % 4) == 3 && (y % 4) == 3) ? 1 : 0;
    endfunction

    function automatic int expCount(int w, int h, int d);
        if (d == 0) return (w - 1) * (h - 1);
        if (d == 1) return (w / 2) * (h / 2);
        return ((w + 1) / 4) * ((h + 1) / 4);
    endfunction

    function automatic int gainR(int v);
`ifdef RAW2RGB_WB_GAIN_EN
        int p;
        p = (v * int'(iWB_R_GAIN)) / 64;
        return (p > 4095) ? 4095 : p;
`else
        return v;
`endif
    endfunction

    function automatic int gainB(int v);
`ifdef RAW2RGB_WB_GAIN_EN
        int p;
        p = (v * int'(iWB_B_GAIN)) / 64;
        return (p > 4095) ? 4095 : p;
`else
        return v;
`endif
    endfunction

    task automatic modelPixel(int y, int x, int d);
        int ok;
        int r;
        int b;
        int gs;
        int c;
        exp_t n;
        pix[y][x] = d;
        ok = (mArmed != 0 && x >= 1 && y >= 1 && passDecim(mDecim, y, x) != 0) ? 1 : 0;
        if (x == 0 && y == 0) begin
            mArmed   = 1;
            mPhase   = int'(iBAYER_PHASE);
            mDecim   = int'(iDECIM);
            mSofPend = 1;
        end
        if (ok != 0) begin
            r  = 0;
            b  = 0;
            gs = 0;
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    c = colourAt(y - dy, x - dx, mPhase);
                    if (c == 0) r = pix[y - dy][x - dx];
                    else if (c == 3) b = pix[y - dy][x - dx];
                    else gs += pix[y - dy][x - dx];
                end
            end
            n.due = cyc + 2;
            n.r   = gainR(r);
            n.g   = gs / 2;
            n.b   = gainB(b);
            n.sof = mSofPend;
            mSofPend = 0;
            expQ.push_back(n);
        end
    endtask

    task automatic drivePixel(int y, int x, int d);
        @(negedge iCLK);
        iDVAL   = 1'b1;
        iX_Cont = CW'(x);
        iY_Cont = CW'(y);
        iDATA   = DW'(d);
        modelPixel(y, x, d);
    endtask

    task automatic idle();
        @(negedge iCLK);
        iDVAL   = 1'b0;
        iDATA   = DW'($urandom_range(0, 4095));
        iX_Cont = CW'($urandom_range(0, 15));
        iY_Cont = CW'($urandom_range(0, 15));
    endtask

    function automatic int dataFor(int mode, int y, int x);
        if (mode == 1) return pat[((y % 2) * 2) + (x % 2)];
        return int'($urandom_range(0, 4095));
    endfunction

    task automatic drain();
        repeat (2) idle();
        repeat (4) @(posedge iCLK);
        #2;
        checkVal("drain_pending", expQ.size(), 0);
    endtask

    task automatic runFrame(input int w, input int h, input int mode, input int gapPct,
                            input int midDecim, input int midPhase,
                            output int nOut, output int nSof);
        outCnt = 0;
        sofCnt = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if ($urandom_range(0, 99) < gapPct) idle();
                if (y == h / 2 && x == 0) begin
                    if (midDecim >= 0) iDECIM = 2'(midDecim);
                    if (midPhase >= 0) iBAYER_PHASE = 2'(midPhase);
                end
                drivePixel(y, x, dataFor(mode, y, x));
            end
            if ($urandom_range(0, 1) == 1) idle();
        end
        drain();
        nOut = outCnt;
        nSof = sofCnt;
    endtask

    always @(posedge iCLK) begin
        #1;
        while (expQ.size() != 0 && expQ[0].due < cyc) begin
            checkVal("missing_output_at_cycle", cyc, expQ[0].due);
            void'(expQ.pop_front());
        end
        if (oDVAL) begin
            outCnt++;
            if (oSOF) sofCnt++;
            if (expQ.size() == 0) begin
                checkVal("unexpected_dval", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkVal("latency_cycle", cyc, e.due);
                checkVal("red", int'(oRed), e.r);
                checkVal("green", int'(oGreen), e.g);
                checkVal("blue", int'(oBlue), e.b);
                checkVal("sof", int'(oSOF), e.sof);
            end
        end else if (oSOF) begin
            checkVal("sof_without_dval", 1, 0);
        end
    end

    int n;
    int s;
    int decCnt[4] = '{105, 32, 8, 8};

    initial begin
        iRST = 1'b1;
        repeat (3) @(negedge iCLK);
        checkVal("reset_red", int'(oRed), 0);
        checkVal("reset_green", int'(oGreen), 0);
        checkVal("reset_blue", int'(oBlue), 0);
        checkVal("reset_dval", int'(oDVAL), 0);
        checkVal("reset_sof", int'(oSOF), 0);
        iRST = 1'b0;

        // Unarmed after reset: a mid-frame row must not produce output
        outCnt = 0;
        for (int x = 0; x < 8; x++) drivePixel(2, x, dataFor(0, 2, x));
        drain();
        checkVal("unarmed_dval_count", outCnt, 0);

        // Flat field, RGGB, full rate
        iBAYER_PHASE = PH_RGGB;
        iDECIM = DEC_FULL;
        runFrame(8, 4, 1, 0, -1, -1, n, s);
        checkVal("flat_count", n, 21);
        checkVal("flat_sof_count", s, 1);
        checkVal("flat_red_hold", int'(oRed), 'h100);
        checkVal("flat_green_hold", int'(oGreen), 'h280);
        checkVal("flat_blue_hold", int'(oBlue), 'h400);

        // Phase sweep on the same mosaic, with input gaps
        for (int ph = 0; ph < 4; ph++) begin
            iBAYER_PHASE = 2'(ph);
            runFrame(8, 4, 1, 20, -1, -1, n, s);
            checkVal($sformatf("phase%0d_count", ph), n, 21);
            checkVal($sformatf("phase%0d_sof_count", ph), s, 1);
        end

        // Decimation modes on a 16x8 random frame
        iBAYER_PHASE = PH_GRBG;
        for (int d = 0; d < 4; d++) begin
            iDECIM = 2'(d);
            runFrame(16, 8, 0, 10, -1, -1, n, s);
            checkVal($sformatf("decim%0d_count", d), n, decCnt[d]);
            checkVal($sformatf("decim%0d_sof_count", d), s, 1);
        end

        // Shadowing: mid-frame decimation change only applies to the next frame
        iDECIM = DEC_FULL;
        runFrame(16, 8, 0, 0, int'(DEC_4X), int'(PH_BGGR), n, s);
        checkVal("shadow_cur_count", n, 105);
        runFrame(16, 8, 0, 0, -1, -1, n, s);
        checkVal("shadow_next_count", n, 8);
        checkVal("shadow_next_sof_count", s, 1);

        // Reset mid-frame at row 3
        iDECIM = DEC_FULL;
        iBAYER_PHASE = PH_GBRG;
        outCnt = 0;
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (y == 3 && x == 2) begin
                    @(negedge iCLK);
                    iRST  = 1'b1;
                    iDVAL = 1'b0;
                    expQ.delete();
                    mArmed   = 0;
                    mSofPend = 0;
                    @(posedge iCLK);
                    #1;
                    checkVal("midrst_red", int'(oRed), 0);
                    checkVal("midrst_green", int'(oGreen), 0);
                    checkVal("midrst_blue", int'(oBlue), 0);
                    checkVal("midrst_dval", int'(oDVAL), 0);
                    iRST = 1'b0;
                    outCnt = 0;
                end
                drivePixel(y, x, dataFor(0, y, x));
            end
        end
        drain();
        checkVal("midrst_no_dval_count", outCnt, 0);
        runFrame(8, 4, 0, 10, -1, -1, n, s);
        checkVal("after_rst_count", n, 21);
        checkVal("after_rst_sof_count", s, 1);

        // Random frame geometry, phase and decimation
        for (int k = 0; k < 6; k++) begin
            int w;
            int h;
            w = int'($urandom_range(4, 16));
            h = int'($urandom_range(4, 8));
            iBAYER_PHASE = 2'($urandom_range(0, 3));
            iDECIM = 2'($urandom_range(0, 3));
            runFrame(w, h, 0, 25, -1, int'($urandom_range(0, 3)), n, s);
            checkVal($sformatf("rand%0d_count", k), n, expCount(w, h, int'(iDECIM)));
            checkVal($sformatf("rand%0d_sof_count", k), s, 1);
        end

`ifdef RAW2RGB_WB_GAIN_EN
        iBAYER_PHASE = PH_RGGB;
        iDECIM = DEC_FULL;
        pat = '{'h800, 'h200, 'h300, 'h400};
        iWB_R_GAIN = 8'h80;
        iWB_B_GAIN = GAIN_ONE;
        runFrame(8, 4, 1, 0, -1, -1, n, s);
        checkVal("gain_sat_red", int'(oRed), 'hFFF);
        checkVal("gain_sat_green", int'(oGreen), 'h280);
        checkVal("gain_unity_blue", int'(oBlue), 'h400);
        pat = '{'h400, 'h200, 'h300, 'h400};
        iWB_R_GAIN = 8'h20;
        runFrame(8, 4, 1, 0, -1, -1, n, s);
        checkVal("gain_half_red", int'(oRed), 'h200);
        checkVal("gain_half_green", int'(oGreen), 'h280);
        iWB_R_GAIN = 8'($urandom_range(0, 255));
        iWB_B_GAIN = 8'($urandom_range(0, 255));
        runFrame(16, 8, 0, 10, -1, -1, n, s);
        checkVal("gain_rand_count", n, 105);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
